// File: rtl/keypad_emulator.sv
// keypad_emulator: responder model of a 4x4 active-low matrix keypad.
// A command presses one key for a given number of cycles, then releases it
// for a fixed gap. While pressed, the key's row is pulled low (registered,
// one cycle after col) whenever the scanner drives that key's column low.
module keypad_emulator #(
   parameter int unsigned HOLD_W     = 24,
   parameter int unsigned GAP_CYCLES = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              key_valid,
   output logic              key_ready,
   input  logic [3:0]        key_code,
   input  logic [HOLD_W-1:0] hold_cycles,
   input  logic              abort,
   input  logic [3:0]        col,
   output logic [3:0]        row,
   output logic              pressed,
   output logic              done,
   output logic [7:0]        hits
);

   localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, PRESS, GAP} state_t;

   state_t            state;
   logic [3:0]        code_q;
   logic [HOLD_W-1:0] hold_cnt;
   logic [GAP_W-1:0]  gap_cnt;
   logic              col_prev;
   logic [1:0]        col_idx;
   logic [1:0]        row_idx;
   logic              col_bit;
   logic              press_stay;

   // Key map: latched code -> column bit and row bit positions (C1/R1 = bit 3)
   always_comb begin
      col_idx = 2'd3;
      row_idx = 2'd3;
      case (code_q)
         4'h1: begin col_idx = 2'd3; row_idx = 2'd3; end
         4'h4: begin col_idx = 2'd3; row_idx = 2'd2; end
         4'h7: begin col_idx = 2'd3; row_idx = 2'd1; end
         4'h0: begin col_idx = 2'd3; row_idx = 2'd0; end
         4'h2: begin col_idx = 2'd2; row_idx = 2'd3; end
         4'h5: begin col_idx = 2'd2; row_idx = 2'd2; end
         4'h8: begin col_idx = 2'd2; row_idx = 2'd1; end
         4'hF: begin col_idx = 2'd2; row_idx = 2'd0; end
         4'h3: begin col_idx = 2'd1; row_idx = 2'd3; end
         4'h6: begin col_idx = 2'd1; row_idx = 2'd2; end
         4'h9: begin col_idx = 2'd1; row_idx = 2'd1; end
         4'hE: begin col_idx = 2'd1; row_idx = 2'd0; end
         4'hA: begin col_idx = 2'd0; row_idx = 2'd3; end
         4'hB: begin col_idx = 2'd0; row_idx = 2'd2; end
         4'hC: begin col_idx = 2'd0; row_idx = 2'd1; end
         default: begin col_idx = 2'd0; row_idx = 2'd0; end
      endcase
   end

   // Held key's column level, and whether this PRESS cycle is not the last one
   always_comb begin
      col_bit    = col[col_idx];
      press_stay = (state == PRESS) && !abort && (hold_cnt != HOLD_W'(1));
   end

   // Command FSM: accept, hold countdown, release gap, done pulse, hit count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         code_q    <= '0;
         hold_cnt  <= '0;
         gap_cnt   <= '0;
         key_ready <= 1'b1;
         pressed   <= 1'b0;
         done      <= 1'b0;
         hits      <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (key_valid) begin
                  code_q    <= key_code;
                  hold_cnt  <= (hold_cycles == '0) ? HOLD_W'(1) : hold_cycles;
                  hits      <= '0;
                  key_ready <= 1'b0;
                  pressed   <= 1'b1;
                  state     <= PRESS;
               end
            end
            PRESS: begin
               if (col_prev && !col_bit && (hits != '1))
                  hits <= hits + 8'd1;
               hold_cnt <= hold_cnt - HOLD_W'(1);
               if (!press_stay) begin
                  pressed <= 1'b0;
                  gap_cnt <= GAP_W'(GAP_CYCLES);
                  state   <= GAP;
               end
            end
            GAP: begin
               if (gap_cnt == GAP_W'(1)) begin
                  key_ready <= 1'b1;
                  done      <= 1'b1;
                  state     <= IDLE;
               end else begin
                  gap_cnt <= gap_cnt - GAP_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Row return and column edge history; the final PRESS cycle already
   // releases the row so nothing is driven once GAP begins
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row      <= 4'b1111;
         col_prev <= 1'b1;
      end else begin
         row      <= (press_stay && !col_bit) ? ~(4'b0001 << row_idx) : 4'b1111;
         col_prev <= (state == PRESS) ? col_bit : 1'b1;
      end
   end

endmodule

// File: tb/tb_keypad_emulator.sv
// Directed bench for keypad_emulator: one task per scenario, inline checks.
module tb_keypad_emulator;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        key_valid = 1'b0;
   logic        key_ready;
   logic [3:0]  key_code = 4'h0;
   logic [23:0] hold_cycles = '0;
   logic        abort = 1'b0;
   logic [3:0]  col = 4'b1111;
   logic [3:0]  row;
   logic        pressed;
   logic        done;
   logic [7:0]  hits;

   int total = 0;
   int bad = 0;

   keypad_emulator #(.HOLD_W(24), .GAP_CYCLES(16)) dut (
      .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_ready(key_ready),
      .key_code(key_code), .hold_cycles(hold_cycles), .abort(abort),
      .col(col), .row(row), .pressed(pressed), .done(done), .hits(hits)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [3:0] pat(input int i);
      case ((i / 25) % 4)
         0: pat = 4'b0111;
         1: pat = 4'b1011;
         2: pat = 4'b1101;
         default: pat = 4'b1110;
      endcase
   endfunction

   // Issue one command for a single cycle; returns in the first PRESS cycle
   task automatic send(input logic [3:0] code, input logic [23:0] hold);
      total++; if (key_ready !== 1'b1) begin bad++; $display("FAIL send_ready: got %b want 1", key_ready); end
      key_valid = 1'b1; key_code = code; hold_cycles = hold;
      tick();
      key_valid = 1'b0;
   endtask

   // Called in the first GAP cycle; ends one cycle after the done cycle
   task automatic run_gap(input int abort_at);
      for (int g = 1; g <= 16; g++) begin
         abort = (g == abort_at);
         total++; if (pressed !== 1'b0) begin bad++; $display("FAIL gap_pressed[%0d]: got %b want 0", g, pressed); end
         total++; if (row !== 4'b1111) begin bad++; $display("FAIL gap_row[%0d]: got %b want 1111", g, row); end
         total++; if (done !== 1'b0) begin bad++; $display("FAIL gap_done[%0d]: got %b want 0", g, done); end
         total++; if (key_ready !== 1'b0) begin bad++; $display("FAIL gap_ready[%0d]: got %b want 0", g, key_ready); end
         tick();
      end
      abort = 1'b0;
      total++; if (done !== 1'b1) begin bad++; $display("FAIL done_pulse: got %b want 1", done); end
      total++; if (key_ready !== 1'b1) begin bad++; $display("FAIL done_ready: got %b want 1", key_ready); end
      total++; if (row !== 4'b1111) begin bad++; $display("FAIL done_row: got %b want 1111", row); end
      tick();
      total++; if (done !== 1'b0) begin bad++; $display("FAIL done_width: got %b want 0", done); end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick(); tick();
      total++; if (row !== 4'b1111) begin bad++; $display("FAIL rst_row: got %b want 1111", row); end
      total++; if (key_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b want 1", key_ready); end
      total++; if (pressed !== 1'b0) begin bad++; $display("FAIL rst_pressed: got %b want 0", pressed); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", done); end
      total++; if (hits !== 8'd0) begin bad++; $display("FAIL rst_hits: got %0d want 0", hits); end
      rst_n = 1'b1;
      tick();
      total++; if (key_ready !== 1'b1) begin bad++; $display("FAIL rst_idle_ready: got %b want 1", key_ready); end
   endtask

   task automatic test_reset_mid_press();
      col = 4'b1011;
      send(4'h5, 24'd50);
      tick(); tick(); tick(); tick();
      total++; if (row !== 4'b1011) begin bad++; $display("FAIL midrst_row_before: got %b want 1011", row); end
      #3 rst_n = 1'b0;
      #1;
      total++; if (row !== 4'b1111) begin bad++; $display("FAIL midrst_row_async: got %b want 1111", row); end
      total++; if (pressed !== 1'b0) begin bad++; $display("FAIL midrst_pressed: got %b want 0", pressed); end
      total++; if (key_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready_async: got %b want 1", key_ready); end
      tick();
      rst_n = 1'b1;
      col = 4'b1111;
      tick();
      total++; if (key_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready: got %b want 1", key_ready); end
      total++; if (hits !== 8'd0) begin bad++; $display("FAIL midrst_hits: got %0d want 0", hits); end
      total++; if (pressed !== 1'b0) begin bad++; $display("FAIL midrst_pressed_after: got %b want 0", pressed); end
   endtask

   task automatic test_basic_press();
      logic [3:0] exp_row;
      col = 4'b1011;
      send(4'h5, 24'd10);
      for (int i = 1; i <= 10; i++) begin
         exp_row = (i >= 2) ? 4'b1011 : 4'b1111;
         total++; if (pressed !== 1'b1) begin bad++; $display("FAIL basic_pressed[%0d]: got %b want 1", i, pressed); end
         total++; if (row !== exp_row) begin bad++; $display("FAIL basic_row[%0d]: got %b want %b", i, row, exp_row); end
         total++; if (key_ready !== 1'b0) begin bad++; $display("FAIL basic_ready[%0d]: got %b want 0", i, key_ready); end
         tick();
      end
      run_gap(0);
      total++; if (hits !== 8'd1) begin bad++; $display("FAIL basic_hits: got %0d want 1", hits); end
      col = 4'b1111;
   endtask

   task automatic test_scan_cycle();
      logic [3:0] exp_row;
      int exp_hits = 0;
      col = pat(0);
      send(4'hD, 24'd300);
      for (int i = 0; i < 300; i++) begin
         col = pat(i);
         if (col[0] == 1'b0 && (i == 0 || pat(i - 1) == 4'b0111 || pat(i - 1) == 4'b1011 || pat(i - 1) == 4'b1101))
            exp_hits++;
         exp_row = (i >= 1 && pat(i - 1) == 4'b1110) ? 4'b1110 : 4'b1111;
         total++; if (row !== exp_row) begin bad++; $display("FAIL scan_row[%0d]: got %b want %b", i, row, exp_row); end
         tick();
      end
      col = 4'b0000;
      total++; if (hits !== 8'(exp_hits)) begin bad++; $display("FAIL scan_hits: got %0d want %0d", hits, exp_hits); end
      run_gap(0);
      col = 4'b1111;
   endtask

   task automatic test_hold_zero();
      col = 4'b1111;
      send(4'h1, 24'd0);
      total++; if (pressed !== 1'b1) begin bad++; $display("FAIL hold0_pressed: got %b want 1", pressed); end
      total++; if (row !== 4'b1111) begin bad++; $display("FAIL hold0_row: got %b want 1111", row); end
      tick();
      run_gap(0);
      total++; if (hits !== 8'd0) begin bad++; $display("FAIL hold0_hits: got %0d want 0", hits); end
   endtask

   task automatic test_saturate();
      logic [3:0] exp_row;
      col = 4'b0111;
      send(4'h1, 24'd600);
      for (int i = 0; i < 600; i++) begin
         col = (i % 2 == 0) ? 4'b0111 : 4'b1111;
         exp_row = (i >= 1 && ((i - 1) % 2 == 0)) ? 4'b0111 : 4'b1111;
         total++; if (row !== exp_row) begin bad++; $display("FAIL sat_row[%0d]: got %b want %b", i, row, exp_row); end
         tick();
      end
      col = 4'b1111;
      total++; if (hits !== 8'd255) begin bad++; $display("FAIL sat_hits: got %0d want 255", hits); end
      run_gap(0);
      total++; if (hits !== 8'd255) begin bad++; $display("FAIL sat_hits_hold: got %0d want 255", hits); end
   endtask

   task automatic test_abort();
      logic [3:0] exp_row;
      col = 4'b1101;
      abort = 1'b1;
      send(4'h9, 24'd500);
      abort = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         exp_row = (i >= 2) ? 4'b1101 : 4'b1111;
         total++; if (pressed !== 1'b1) begin bad++; $display("FAIL abort_pressed[%0d]: got %b want 1", i, pressed); end
         total++; if (row !== exp_row) begin bad++; $display("FAIL abort_row[%0d]: got %b want %b", i, row, exp_row); end
         abort = (i == 20);
         tick();
      end
      abort = 1'b0;
      run_gap(5);
      total++; if (hits !== 8'd1) begin bad++; $display("FAIL abort_hits: got %0d want 1", hits); end
      col = 4'b1111;
   endtask

   task automatic test_back_to_back();
      logic [3:0] exp_row;
      col = 4'b0000;
      total++; if (key_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready0: got %b want 1", key_ready); end
      key_valid = 1'b1; key_code = 4'h2; hold_cycles = 24'd3;
      tick();
      for (int i = 1; i <= 3; i++) begin
         exp_row = (i >= 2) ? 4'b0111 : 4'b1111;
         total++; if (pressed !== 1'b1) begin bad++; $display("FAIL b2b_pressed[%0d]: got %b want 1", i, pressed); end
         total++; if (key_ready !== 1'b0) begin bad++; $display("FAIL b2b_ready[%0d]: got %b want 0", i, key_ready); end
         total++; if (row !== exp_row) begin bad++; $display("FAIL b2b_row[%0d]: got %b want %b", i, row, exp_row); end
         tick();
      end
      key_code = 4'hA; hold_cycles = 24'd4;
      total++; if (hits !== 8'd1) begin bad++; $display("FAIL b2b_hits_first: got %0d want 1", hits); end
      run_gap(0);
      total++; if (pressed !== 1'b1) begin bad++; $display("FAIL b2b_second_accept: got %b want 1", pressed); end
      total++; if (hits !== 8'd0) begin bad++; $display("FAIL b2b_hits_clear: got %0d want 0", hits); end
      key_valid = 1'b0;
      tick();
      total++; if (row !== 4'b0111) begin bad++; $display("FAIL b2b_rowA: got %b want 0111", row); end
      total++; if (hits !== 8'd1) begin bad++; $display("FAIL b2b_hitsA: got %0d want 1", hits); end
      tick(); tick(); tick();
      run_gap(0);
      col = 4'b1111;
   endtask

   initial begin
      test_reset();
      test_reset_mid_press();
      test_basic_press();
      test_scan_cycle();
      test_hold_zero();
      test_saturate();
      test_abort();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
